// File: rtl/mem_sync_pkg.sv
// Shared types, parameter defaults and the power-on fill pattern for mem_sync_port.
package mem_sync_pkg;

  localparam int MEM_DW_DEF     = 8;
  localparam int MEM_DEPTH_DEF  = 256;
  localparam int MEM_AW_DEF     = 8;
  localparam int MEM_RD_LAT_DEF = 1;

  typedef enum logic {
    MEM_INIT = 1'b0,
    MEM_RUN  = 1'b1
  } mem_state_e;

  // Full-width square; callers truncate to their word width.
  function automatic logic [63:0] init_word(input logic [31:0] idx);
    return 64'(idx) * 64'(idx);
  endfunction

endpackage

// File: rtl/mem_sync_port_if.sv
// Request/response bundle between the memory and its requester.
// inj_perr exists only when MEM_PARITY_EN is defined.
interface mem_sync_port_if
  import mem_sync_pkg::*;
#(
  parameter int DW = MEM_DW_DEF,
  parameter int AW = MEM_AW_DEF
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          init_done;
`ifdef MEM_PARITY_EN
  logic          inj_perr;
`endif

  modport slave (
`ifdef MEM_PARITY_EN
    input  inj_perr,
`endif
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport master (
`ifdef MEM_PARITY_EN
    output inj_perr,
`endif
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

endinterface

// File: rtl/mem_rd_pipe.sv
// RD_LAT-deep response delay line; a stage loads only when valid data arrives,
// so the last stage holds its data/err while no response is flowing.
module mem_rd_pipe
  import mem_sync_pkg::*;
#(
  parameter int DW     = MEM_DW_DEF,
  parameter int RD_LAT = MEM_RD_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic [DW-1:0] in_dat,
  input  logic          in_err,
  output logic          out_vld,
  output logic [DW-1:0] out_dat,
  output logic          out_err
);

  logic [RD_LAT-1:0] vld;
  logic [RD_LAT-1:0] err;
  logic [DW-1:0]     dat [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      err <= '0;
      for (int i = 0; i < RD_LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_vld;
      if (in_vld) begin
        dat[0] <= in_dat;
        err[0] <= in_err;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          dat[i] <= dat[i-1];
          err[i] <= err[i-1];
        end
      end
    end
  end

  assign out_vld = vld[RD_LAT-1];
  assign out_dat = dat[RD_LAT-1];
  assign out_err = err[RD_LAT-1];

endmodule

// File: rtl/mem_sync_port.sv
// Single-port synchronous memory: fills mem[i]=i*i after reset, then serves one request per cycle.
// MEM_PARITY_EN adds a stored even-parity bit per word and the inj_perr input.
module mem_sync_port
  import mem_sync_pkg::*;
#(
  parameter int DW     = MEM_DW_DEF,
  parameter int DEPTH  = MEM_DEPTH_DEF,
  parameter int AW     = MEM_AW_DEF,
  parameter int RD_LAT = MEM_RD_LAT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_sync_port_if.slave  bus
);

  localparam int IW = $clog2(DEPTH);
`ifdef MEM_PARITY_EN
  localparam int WW = DW + 1;
`else
  localparam int WW = DW;
`endif

  mem_state_e    state, state_nxt;
  logic [IW-1:0] cnt, cnt_nxt;
  logic          run;

  logic [WW-1:0] mem [DEPTH];
  logic          we;
  logic [IW-1:0] wa;
  logic [WW-1:0] wd;

  logic          acc;
  logic          in_range;
  logic [IW-1:0] idx;
  logic [IW-1:0] rd_idx;
  logic [WW-1:0] rword;
  logic [DW-1:0] init_dat;
  logic [DW-1:0] rd_dat;
  logic          rd_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MEM_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    run       = 1'b0;
    case (state)
      MEM_INIT: begin
        cnt_nxt = cnt + IW'(1);
        if (cnt == IW'(DEPTH - 1)) begin
          state_nxt = MEM_RUN;
          cnt_nxt   = '0;
        end
      end
      MEM_RUN: run = 1'b1;
      default: state_nxt = MEM_INIT;
    endcase
  end

  assign bus.req_ready = run;
  assign bus.init_done = run;

  assign acc      = bus.req_valid && run;
  assign in_range = 32'(bus.req_addr) < 32'(DEPTH);
  assign idx      = IW'(bus.req_addr);
  assign rd_idx   = in_range ? idx : '0;
  assign init_dat = DW'(init_word(32'(cnt)));

  // The sweep owns the write port until RUN; afterwards only in-range writes land.
  always_comb begin
    we = 1'b0;
    wa = cnt;
`ifdef MEM_PARITY_EN
    wd = {^init_dat, init_dat};
`else
    wd = init_dat;
`endif
    if (state == MEM_INIT) begin
      we = 1'b1;
    end else if (acc && bus.req_write && in_range) begin
      we = 1'b1;
      wa = idx;
`ifdef MEM_PARITY_EN
      wd = {(^bus.req_wdata) ^ bus.inj_perr, bus.req_wdata};
`else
      wd = bus.req_wdata;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Read is combinational from the array ahead of the edge, so it sees pre-write contents.
  assign rword  = mem[rd_idx];
  assign rd_dat = in_range ? rword[DW-1:0] : '0;
`ifdef MEM_PARITY_EN
  assign rd_err = !in_range || (^rword);
`else
  assign rd_err = !in_range;
`endif

  mem_rd_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (acc && !bus.req_write),
    .in_dat  (rd_dat),
    .in_err  (rd_err),
    .out_vld (bus.rsp_valid),
    .out_dat (bus.rsp_rdata),
    .out_err (bus.rsp_err)
  );

endmodule
